// File: rtl/pcileech_rst_ctl.sv
// pcileech_rst_ctl: startup/reset sequencer for the board top.
// POR delay, FT601 reset pulse and boot wait, button re-run, PCIe reset gating.
module pcileech_rst_ctl #(
  parameter int unsigned PARAM_POR_CYCLES      = 64,
  parameter int unsigned PARAM_FTRST_CYCLES    = 16,
  parameter int unsigned PARAM_FTBOOT_CYCLES   = 1024,
  parameter int unsigned PARAM_DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_rst,
  input  logic       pcie_perst_n,
  output logic       rst_sys,
  output logic       ft601_rst_n,
  output logic       pcie_rst,
  output logic       led_state,
  output logic [1:0] rst_cause
);

  localparam logic [31:0] C_POR =
    (PARAM_POR_CYCLES == 0) ? 32'd1 : 32'(PARAM_POR_CYCLES);
  localparam logic [31:0] C_FTRST =
    (PARAM_FTRST_CYCLES == 0) ? 32'd1 : 32'(PARAM_FTRST_CYCLES);
  localparam logic [31:0] C_FTBOOT =
    (PARAM_FTBOOT_CYCLES == 0) ? 32'd1 : 32'(PARAM_FTBOOT_CYCLES);
  localparam logic [31:0] C_DB =
    (PARAM_DEBOUNCE_CYCLES == 0) ? 32'd1 : 32'(PARAM_DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    S_HOLD,
    S_POR,
    S_FTRST,
    S_FTBOOT,
    S_RUN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cnt;
  logic [1:0]  r_btn_s;
  logic [1:0]  r_perst_s;
  logic        r_btn_db;
  logic [31:0] r_db_cnt;
  logic [1:0]  r_rst_cause;
  logic        w_btn_sync;
  logic        w_perst_sync;
  logic        w_db_diff;
  logic        w_db_done;
  logic        w_db_rise;
  logic        w_cause_set;

  assign w_btn_sync   = r_btn_s[1];
  assign w_perst_sync = r_perst_s[1];
  assign w_db_diff    = w_btn_sync ^ r_btn_db;
  assign w_db_done    = w_db_diff && (r_db_cnt == C_DB - 32'd1);
  assign w_db_rise    = w_db_done && !r_btn_db;
  assign rst_cause    = r_rst_cause;

  // two-flop synchronisers for the raw async button and PERST#
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s   <= 2'b00;
      r_perst_s <= 2'b00;
    end else begin
      r_btn_s   <= {r_btn_s[0], btn_rst};
      r_perst_s <= {r_perst_s[0], pcie_perst_n};
    end
  end

  // debounce: accept a new level after C_DB consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_db <= 1'b0;
      r_db_cnt <= 32'd0;
    end else if (!w_db_diff) begin
      r_db_cnt <= 32'd0;
    end else if (w_db_done) begin
      r_db_cnt <= 32'd0;
      r_btn_db <= ~r_btn_db;
    end else begin
      r_db_cnt <= r_db_cnt + 32'd1;
    end
  end

  // next-state logic; a debounced button press overrides any exit
  always_comb begin
    w_next      = r_state;
    w_cause_set = 1'b0;
    unique case (r_state)
      S_HOLD:   if (!r_btn_db) w_next = S_POR;
      S_POR:    if (r_cnt == C_POR - 32'd1) w_next = S_FTRST;
      S_FTRST:  if (r_cnt == C_FTRST - 32'd1) w_next = S_FTBOOT;
      S_FTBOOT: if (r_cnt == C_FTBOOT - 32'd1) w_next = S_RUN;
      S_RUN:    w_next = S_RUN;
      default:  w_next = S_HOLD;
    endcase
    if (r_state != S_HOLD && w_db_rise) begin
      w_next      = S_HOLD;
      w_cause_set = 1'b1;
    end
  end

  // state, saturating phase counter and reset cause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_HOLD;
      r_cnt       <= 32'd0;
      r_rst_cause <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= 32'd0;
      end else if (r_cnt != 32'hFFFF_FFFF) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_cause_set) begin
        r_rst_cause <= 2'd1;
      end
    end
  end

  // registered output decode, one cycle behind the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sys     <= 1'b1;
      ft601_rst_n <= 1'b0;
      pcie_rst    <= 1'b1;
      led_state   <= 1'b0;
    end else begin
      rst_sys     <= (r_state != S_RUN);
      ft601_rst_n <= (r_state == S_FTBOOT) || (r_state == S_RUN);
      pcie_rst    <= (r_state != S_RUN) || !w_perst_sync;
      led_state   <= (r_state == S_RUN);
    end
  end

endmodule

// File: tb/tb_pcileech_rst_ctl.sv
// tb_pcileech_rst_ctl: directed and randomized checks of the
// reset sequencer against an elapsed-time reference model.
module tb_pcileech_rst_ctl;

  localparam int POR = 4;
  localparam int FTR = 2;
  localparam int FTB = 8;
  localparam int DB  = 3;
  localparam int TOT = POR + FTR + FTB;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_rst;
  logic       pcie_perst_n;
  logic       rst_sys;
  logic       ft601_rst_n;
  logic       pcie_rst;
  logic       led_state;
  logic [1:0] rst_cause;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // model state: sync pipes, debounce history, elapsed time since HOLD exit
  bit       m_bs0, m_bs1, m_ps0, m_ps1;
  bit       m_db;
  bit       hist[$];
  bit       m_hold;
  int       m_t;
  bit       e_rs, e_ft, e_pr, e_led;
  bit [1:0] e_cause;

  pcileech_rst_ctl #(
    .PARAM_POR_CYCLES      (POR),
    .PARAM_FTRST_CYCLES    (FTR),
    .PARAM_FTBOOT_CYCLES   (FTB),
    .PARAM_DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_rst      (btn_rst),
    .pcie_perst_n (pcie_perst_n),
    .rst_sys      (rst_sys),
    .ft601_rst_n  (ft601_rst_n),
    .pcie_rst     (pcie_rst),
    .led_state    (led_state),
    .rst_cause    (rst_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bs0 = 0; m_bs1 = 0; m_ps0 = 0; m_ps1 = 0;
    m_db = 0;
    hist.delete();
    m_hold = 1; m_t = 0;
    e_rs = 1; e_ft = 0; e_pr = 1; e_led = 0; e_cause = 2'd0;
  endtask

  task automatic model_edge();
    bit bsync, psync, flip, rise, run;
    bsync = m_bs1;
    psync = m_ps1;
    flip  = 0;
    run   = !m_hold && (m_t >= TOT);
    e_rs  = !run;
    e_ft  = !m_hold && (m_t >= POR + FTR);
    e_led = run;
    e_pr  = !run || !psync;
    if (bsync == m_db) hist.delete();
    else begin
      hist.push_back(bsync);
      if (hist.size() >= DB) flip = 1;
    end
    rise = flip && !m_db;
    if (m_hold) begin
      if (!m_db) begin
        m_hold = 0;
        m_t = 0;
      end
    end else if (rise) begin
      m_hold = 1;
      e_cause = 2'd1;
    end else if (m_t < TOT) begin
      m_t++;
    end
    if (flip) begin
      m_db = !m_db;
      hist.delete();
    end
    m_bs1 = m_bs0; m_bs0 = btn_rst;
    m_ps1 = m_ps0; m_ps0 = pcie_perst_n;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    chk("rst_sys", 32'(rst_sys), 32'(e_rs));
    chk("ft601_rst_n", 32'(ft601_rst_n), 32'(e_ft));
    chk("pcie_rst", 32'(pcie_rst), 32'(e_pr));
    chk("led_state", 32'(led_state), 32'(e_led));
    chk("rst_cause", 32'(rst_cause), 32'(e_cause));
  endtask

  task automatic seq_timing(string tag);
    int ft_at, rs_at;
    ft_at = -1;
    rs_at = -1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (ft_at < 0 && ft601_rst_n === 1'b1) ft_at = k;
      if (rs_at < 0 && rst_sys === 1'b0) rs_at = k;
    end
    chk({tag, "_ft_rise"}, ft_at, 1 + 1 + POR + FTR);
    chk({tag, "_run"}, rs_at, 1 + TOT + 1);
    chk({tag, "_led"}, 32'(led_state), 1);
    chk({tag, "_pcie"}, 32'(pcie_rst), 0);
  endtask

  initial begin
    int at;
    rst = 1'b1;
    btn_rst = 1'b0;
    pcie_perst_n = 1'b1;
    model_reset();
    repeat (3) cyc();
    chk("reset_rst_sys", 32'(rst_sys), 1);
    chk("reset_ft601", 32'(ft601_rst_n), 0);

    // power-up sequence
    rst = 1'b0;
    seq_timing("t1");

    // short pulse is rejected
    btn_rst = 1'b1;
    repeat (2) cyc();
    btn_rst = 1'b0;
    repeat (10) cyc();
    chk("t2_rst_sys", 32'(rst_sys), 0);
    chk("t2_cause", 32'(rst_cause), 0);

    // long press returns to HOLD, release reruns
    btn_rst = 1'b1;
    at = -1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (at < 0 && rst_sys === 1'b1) at = k;
    end
    chk("t3_press", at, 2 + DB + 1);
    chk("t3_cause", 32'(rst_cause), 1);
    chk("t3_ft601", 32'(ft601_rst_n), 0);
    btn_rst = 1'b0;
    repeat (40) cyc();
    chk("t3_rerun", 32'(led_state), 1);

    // PERST# only gates pcie_rst
    pcie_perst_n = 1'b0;
    at = -1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (at < 0 && pcie_rst === 1'b1) at = k;
    end
    chk("t4_fall", at, 3);
    pcie_perst_n = 1'b1;
    at = -1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (at < 0 && pcie_rst === 1'b0) at = k;
    end
    chk("t4_rise", at, 3);
    chk("t4_led", 32'(led_state), 1);

    // async reset mid FTBOOT
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (12) cyc();
    chk("t5_pre_ft601", 32'(ft601_rst_n), 1);
    rst = 1'b1;
    #1;
    chk("t5_async_ft601", 32'(ft601_rst_n), 0);
    chk("t5_async_rst_sys", 32'(rst_sys), 1);
    chk("t5_async_pcie", 32'(pcie_rst), 1);
    chk("t5_async_cause", 32'(rst_cause), 0);
    repeat (2) cyc();
    rst = 1'b0;
    seq_timing("t5");

    // randomized button bounce, PERST# and hard resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) btn_rst = ~btn_rst;
      if ($urandom_range(0, 19) == 0) pcie_perst_n = ~pcie_perst_n;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
